armazena_cubo: RTL and testbench

Downstream consumer of the colour-identification stage. It captures the stream of per-sticker colour codes (`we_cor`, `linha_pixel_addr`, `coluna_pixel_addr`, `cor_final`) for each of the six cube faces into a 54-entry colour memory. After the sixth face it scans the memory to check colour counts. It then exposes the cube state through a read port to the solver stage.

---
 rtl/armazena_cubo_if.sv | 32 +++
 rtl/armazena_cubo.sv | 119 +++++++++++
 tb/tb_armazena_cubo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/armazena_cubo_if.sv
// Handshake/bus bundle between the colour stage, this cube store and the solver.
interface armazena_cubo_if;
  logic       iniciar;
  logic       iniciar_face;
  logic       we_cor;
  logic [1:0] linha_pixel_addr;
  logic [1:0] coluna_pixel_addr;
  logic [2:0] cor_final;
  logic       pronto_cores;
  logic [5:0] rd_addr;
  logic [2:0] rd_cor;
  logic [2:0] face_atual;
  logic       face_pronta;
  logic       erro_face;
  logic       cubo_pronto;
  logic       cubo_valido;
  logic [3:0] db_estado;

  modport master (
    output iniciar, iniciar_face, we_cor, linha_pixel_addr, coluna_pixel_addr,
           cor_final, pronto_cores, rd_addr,
    input  rd_cor, face_atual, face_pronta, erro_face, cubo_pronto, cubo_valido,
           db_estado
  );

  modport slave (
    input  iniciar, iniciar_face, we_cor, linha_pixel_addr, coluna_pixel_addr,
           cor_final, pronto_cores, rd_addr,
    output rd_cor, face_atual, face_pronta, erro_face, cubo_pronto, cubo_valido,
           db_estado
  );
endinterface

// File: rtl/armazena_cubo.sv
// Captures six faces of sticker colours into a 54-entry memory, checks colour
// counts after the last face and serves the cube state on a registered read port.
module armazena_cubo #(
  parameter int NUM_FACES        = 6,
  parameter int STICKERS_POR_COR = 9
) (
  input  logic           clock,
  input  logic           reset,
  armazena_cubo_if.slave bus
);
  localparam int NUM_POS = NUM_FACES * 9;

  localparam logic [3:0] INICIAL     = 4'd0;
  localparam logic [3:0] ESPERA_FACE = 4'd1;
  localparam logic [3:0] CAPTURA     = 4'd2;
  localparam logic [3:0] FIM_FACE    = 4'd3;
  localparam logic [3:0] VERIFICA    = 4'd4;
  localparam logic [3:0] DECIDE      = 4'd5;
  localparam logic [3:0] FIM         = 4'd6;

  logic [3:0] estado, prox;
  logic [2:0] face;
  logic [8:0] mask;
  logic [5:0] scan_addr;
  logic [5:0] cnt [0:5];
  logic       invalido;
  logic       valido;
  logic [2:0] rd_cor_q;
  logic [2:0] mem [0:NUM_POS-1];

  logic       pos_ok;
  logic [3:0] pos_idx;
  logic [5:0] wr_addr;
  logic       wr_en;
  logic       mask_cheio;
  logic       ultima_face;
  logic       fim_scan;
  logic [2:0] cor_scan;
  logic       contagem_ok;

  assign pos_ok      = (bus.linha_pixel_addr != 2'd3) && (bus.coluna_pixel_addr != 2'd3);
  assign pos_idx     = {2'b00, bus.linha_pixel_addr} * 4'd3 + {2'b00, bus.coluna_pixel_addr};
  assign wr_addr     = {face, 3'b000} + {3'b000, face} + {2'b00, pos_idx};
  assign wr_en       = (estado == CAPTURA) && bus.we_cor && pos_ok;
  assign mask_cheio  = &mask;
  assign ultima_face = (face == 3'(NUM_FACES - 1));
  assign fim_scan    = (scan_addr == 6'(NUM_POS - 1));
  assign cor_scan    = mem[scan_addr];

  always_comb begin
    contagem_ok = 1'b1;
    for (int unsigned i = 0; i < 6; i++)
      if (cnt[i] != 6'(STICKERS_POR_COR)) contagem_ok = 1'b0;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     if (bus.iniciar) prox = ESPERA_FACE;
      ESPERA_FACE: if (bus.iniciar_face) prox = CAPTURA;
      CAPTURA:     if (bus.pronto_cores) prox = FIM_FACE;
      FIM_FACE:    prox = (mask_cheio && ultima_face) ? VERIFICA : ESPERA_FACE;
      VERIFICA:    if (fim_scan) prox = DECIDE;
      DECIDE:      prox = FIM;
      FIM:         if (bus.iniciar) prox = ESPERA_FACE;
      default:     prox = INICIAL;
    endcase
  end

  // Memory has no reset; its contents are only trusted after a full capture.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= bus.cor_final;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= INICIAL;
      face      <= '0;
      mask      <= '0;
      scan_addr <= '0;
      invalido  <= 1'b0;
      valido    <= 1'b0;
      rd_cor_q  <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      estado   <= prox;
      rd_cor_q <= (bus.rd_addr < 6'(NUM_POS)) ? mem[bus.rd_addr] : '0;

      if (((estado == INICIAL) || (estado == FIM)) && bus.iniciar) begin
        face      <= '0;
        scan_addr <= '0;
        invalido  <= 1'b0;
        valido    <= 1'b0;
        for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
      end

      if ((estado == ESPERA_FACE) && bus.iniciar_face) mask <= '0;
      if (wr_en) mask[pos_idx] <= 1'b1;

      if ((estado == FIM_FACE) && mask_cheio && !ultima_face) face <= face + 3'd1;

      if (estado == VERIFICA) begin
        scan_addr <= scan_addr + 6'd1;
        if (cor_scan <= 3'd5) cnt[cor_scan] <= cnt[cor_scan] + 6'd1;
        else                  invalido      <= 1'b1;
      end

      if (estado == DECIDE) valido <= contagem_ok && !invalido;
    end
  end

  assign bus.rd_cor      = rd_cor_q;
  assign bus.face_atual  = face;
  assign bus.face_pronta = (estado == FIM_FACE) && mask_cheio;
  assign bus.erro_face   = (estado == FIM_FACE) && !mask_cheio;
  assign bus.cubo_pronto = (estado == FIM);
  assign bus.cubo_valido = valido;
  assign bus.db_estado   = estado;
endmodule

// File: tb/tb_armazena_cubo.sv
// Self-checking bench for armazena_cubo: scenario table of cube captures plus
// a read-port scoreboard and a reset-during-scan sequence.
module tb_armazena_cubo;
  logic clock = 1'b0;
  logic reset = 1'b1;

  armazena_cubo_if bus ();

  armazena_cubo #(.NUM_FACES(6), .STICKERS_POR_COR(9)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       alt1_addr;
    logic [2:0] alt1_cor;
    int       alt2_addr;
    logic [2:0] alt2_cor;
    int       bad_face;
    int       ovr_face;
    int       sim_face;
    bit       reset_mid;
    int       exp_valido;
  } cenario_t;

  cenario_t   cenarios [5];
  logic [2:0] exp_mem [54];
  logic [2:0] sb [$];
  int         rd_tab [11] = '{0, 4, 13, 22, 26, 40, 44, 49, 53, 54, 63};
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nome, input int atual, input int esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic sb_compare(input string nome);
    logic [2:0] e;
    if (sb.size() == 0) begin
      check({nome, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check(nome, int'(bus.rd_cor), int'(e));
    end
  endtask

  task automatic attempt(input int f, input bit full, input bit ovr, input bit sim);
    bus.iniciar_face = 1'b1;
    tick();
    bus.iniciar_face = 1'b0;
    check("captura_db", int'(bus.db_estado), 2);
    for (int p = 0; p < 9; p++) begin
      if (!full && p == 8) begin
        bus.we_cor = 1'b1; bus.linha_pixel_addr = 2'd3; bus.coluna_pixel_addr = 2'd0;
        bus.cor_final = 3'd6;
        tick();
      end else begin
        if (ovr && p == 4) begin
          bus.we_cor = 1'b1; bus.linha_pixel_addr = 2'd1; bus.coluna_pixel_addr = 2'd1;
          bus.cor_final = 3'd3;
          tick();
        end
        bus.we_cor = 1'b1;
        bus.linha_pixel_addr  = 2'(p / 3);
        bus.coluna_pixel_addr = 2'(p % 3);
        bus.cor_final = exp_mem[f*9 + p];
        if (sim && full && p == 8) bus.pronto_cores = 1'b1;
        tick();
      end
    end
    bus.we_cor = 1'b0;
    if (!(sim && full)) begin
      bus.pronto_cores = 1'b1;
      tick();
    end
    bus.pronto_cores = 1'b0;
    check("fim_face_db", int'(bus.db_estado), 3);
    check("face_pronta", int'(bus.face_pronta), full ? 1 : 0);
    check("erro_face", int'(bus.erro_face), full ? 0 : 1);
    tick();
    check("face_pronta_pulse", int'(bus.face_pronta), 0);
    check("face_atual_next", int'(bus.face_atual), (full && f < 5) ? f + 1 : f);
    check("db_after_face", int'(bus.db_estado), (full && f == 5) ? 4 : 1);
  endtask

  task automatic run_cube(input cenario_t c);
    int cnt;
    for (int a = 0; a < 54; a++) exp_mem[a] = 3'(a / 9);
    if (c.alt1_addr >= 0) exp_mem[c.alt1_addr] = c.alt1_cor;
    if (c.alt2_addr >= 0) exp_mem[c.alt2_addr] = c.alt2_cor;

    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    check("start_db", int'(bus.db_estado), 1);
    check("start_face", int'(bus.face_atual), 0);
    check("start_cubo_pronto", int'(bus.cubo_pronto), 0);
    check("start_cubo_valido", int'(bus.cubo_valido), 0);

    for (int f = 0; f < 6; f++) begin
      if (f == c.bad_face) begin
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        check("iniciar_ignored_face", int'(bus.face_atual), f);
        check("iniciar_ignored_db", int'(bus.db_estado), 1);
        attempt(f, 1'b0, 1'b0, 1'b0);
      end
      attempt(f, 1'b1, f == c.ovr_face, f == c.sim_face);
    end

    if (c.reset_mid) begin
      repeat (20) tick();
      check("mid_scan_db", int'(bus.db_estado), 4);
      reset = 1'b1;
      #1;
      check("rst_db", int'(bus.db_estado), 0);
      check("rst_face", int'(bus.face_atual), 0);
      check("rst_rd_cor", int'(bus.rd_cor), 0);
      check("rst_flags", int'({bus.face_pronta, bus.erro_face, bus.cubo_pronto, bus.cubo_valido}), 0);
      #1 reset = 1'b0;
      tick();
      check("post_rst_db", int'(bus.db_estado), 0);
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      check("restart_db", int'(bus.db_estado), 1);
      check("restart_face", int'(bus.face_atual), 0);
      attempt(0, 1'b1, 1'b0, 1'b0);
      return;
    end

    cnt = 1;
    while (!bus.cubo_pronto && cnt < 200) begin
      if (cnt == 10) begin
        bus.rd_addr = 6'd40;
        sb.push_back(exp_mem[40]);
      end
      tick();
      cnt++;
      if (cnt == 11) sb_compare("rd_during_scan");
    end
    check("latency", cnt, 56);
    check("cubo_valido", int'(bus.cubo_valido), c.exp_valido);
    check("fim_db", int'(bus.db_estado), 6);

    for (int i = 0; i < 11; i++) begin
      bus.rd_addr = 6'(rd_tab[i]);
      sb.push_back(rd_tab[i] < 54 ? exp_mem[rd_tab[i]] : 3'd0);
      tick();
      sb_compare($sformatf("rd_%0d", rd_tab[i]));
    end
    check("cubo_pronto_held", int'(bus.cubo_pronto), 1);
    check("cubo_valido_held", int'(bus.cubo_valido), c.exp_valido);
  endtask

  initial begin
    bus.iniciar = 1'b0; bus.iniciar_face = 1'b0; bus.we_cor = 1'b0;
    bus.linha_pixel_addr = '0; bus.coluna_pixel_addr = '0; bus.cor_final = '0;
    bus.pronto_cores = 1'b0; bus.rd_addr = '0;

    // alt1, alt2, bad_face, ovr_face, sim_face, reset_mid, exp_valido
    cenarios[0] = '{-1, 3'd0, -1, 3'd0,  2,  5,  5, 1'b0, 1};
    cenarios[1] = '{ 0, 3'd1, -1, 3'd0, -1, -1,  0, 1'b0, 0};
    cenarios[2] = '{ 0, 3'd7, -1, 3'd0,  4, -1, -1, 1'b0, 0};
    cenarios[3] = '{ 0, 3'd1,  9, 3'd0, -1, -1, -1, 1'b0, 1};
    cenarios[4] = '{-1, 3'd0, -1, 3'd0, -1, -1, -1, 1'b1, 0};

    #13;
    check("reset_db", int'(bus.db_estado), 0);
    check("reset_face", int'(bus.face_atual), 0);
    check("reset_rd_cor", int'(bus.rd_cor), 0);
    check("reset_flags", int'({bus.face_pronta, bus.erro_face, bus.cubo_pronto, bus.cubo_valido}), 0);
    reset = 1'b0;
    tick();
    check("idle_db", int'(bus.db_estado), 0);

    for (int s = 0; s < 5; s++) run_cube(cenarios[s]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
